// File: rtl/cpu_run_dump_ctrl.sv
// Run-and-dump controller for the i281 CPU. It gates the CPU clock enable for a
// bounded run, then streams data-memory words 0..DEPTH-1 out over valid/ready.
module cpu_run_dump_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 4000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_in,
  output logic              cpu_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  cycles_run
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(DEPTH - 1);
  localparam logic [CYC_W-1:0]  BUDGET_LAST = CYC_W'(MAX_CYCLES - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                cpu_en_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_rd_addr_q;
  logic                dump_valid_q;
  logic [ADDR_W-1:0]   dump_addr_q;
  logic [DATA_W-1:0]   dump_data_q;
  logic                busy_q;
  logic                done_q;
  logic                timeout_q;
  logic [CYC_W-1:0]    cycles_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cpu_en_q      <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      dump_valid_q  <= 1'b0;
      dump_addr_q   <= '0;
      dump_data_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycles_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            cpu_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
          end
        end

        S_RUN: begin
          // The exiting cycle still counts: the CPU was enabled during it.
          cycles_q <= cycles_q + CYC_W'(1);
          if (halt_in || (cycles_q == BUDGET_LAST)) begin
            state_q       <= S_READ;
            cpu_en_q      <= 1'b0;
            timeout_q     <= ~halt_in;
            idx_q         <= '0;
            mem_rd_en_q   <= 1'b1;
            mem_rd_addr_q <= '0;
          end
        end

        S_READ: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= S_WAIT;
        end

        S_WAIT: begin
          dump_data_q  <= mem_rd_data;
          dump_addr_q  <= idx_q;
          dump_valid_q <= 1'b1;
          state_q      <= S_PRESENT;
        end

        S_PRESENT: begin
          // Index only advances below LAST_IDX, so a full-range DEPTH never wraps.
          if (dump_ready) begin
            dump_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q         <= idx_q + ADDR_W'(1);
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= idx_q + ADDR_W'(1);
              state_q       <= S_READ;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_en      = cpu_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign dump_valid  = dump_valid_q;
  assign dump_addr   = dump_addr_q;
  assign dump_data   = dump_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycles_run  = cycles_q;

endmodule

// File: tb/tb_cpu_run_dump_ctrl.sv
// Directed bench for cpu_run_dump_ctrl: budget/halt exits, dump ordering,
// backpressure, mid-dump reset, restart from DONE and a DEPTH=4 build.
module tb_cpu_run_dump_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt, words, cyc;

  // Instance A: MAX_CYCLES=8, DEPTH=16
  logic a_start = 0, a_halt = 0, a_ready = 0;
  logic a_cpu_en, a_rd_en, a_valid, a_busy, a_done, a_timeout;
  logic [3:0]  a_rd_addr, a_dump_addr;
  logic [15:0] a_rd_data, a_dump_data, a_cycles;

  // Instance B: MAX_CYCLES=4000, DEPTH=16
  logic b_start = 0, b_halt = 0, b_ready = 0;
  logic b_cpu_en, b_rd_en, b_valid, b_busy, b_done, b_timeout;
  logic [3:0]  b_rd_addr, b_dump_addr;
  logic [15:0] b_rd_data, b_dump_data, b_cycles;

  // Instance C: MAX_CYCLES=8, DEPTH=4
  logic c_start = 0, c_halt = 0, c_ready = 0;
  logic c_cpu_en, c_rd_en, c_valid, c_busy, c_done, c_timeout;
  logic [3:0]  c_rd_addr, c_dump_addr;
  logic [15:0] c_rd_data, c_dump_data, c_cycles;

  cpu_run_dump_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CYC_W(16), .MAX_CYCLES(8)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .halt_in(a_halt), .cpu_en(a_cpu_en),
    .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
    .dump_valid(a_valid), .dump_ready(a_ready), .dump_addr(a_dump_addr), .dump_data(a_dump_data),
    .busy(a_busy), .done(a_done), .timeout(a_timeout), .cycles_run(a_cycles));

  cpu_run_dump_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .CYC_W(16), .MAX_CYCLES(4000)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .halt_in(b_halt), .cpu_en(b_cpu_en),
    .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
    .dump_valid(b_valid), .dump_ready(b_ready), .dump_addr(b_dump_addr), .dump_data(b_dump_data),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .cycles_run(b_cycles));

  cpu_run_dump_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(4), .CYC_W(16), .MAX_CYCLES(8)) dut_c (
    .clock(clock), .reset(reset), .start(c_start), .halt_in(c_halt), .cpu_en(c_cpu_en),
    .mem_rd_en(c_rd_en), .mem_rd_addr(c_rd_addr), .mem_rd_data(c_rd_data),
    .dump_valid(c_valid), .dump_ready(c_ready), .dump_addr(c_dump_addr), .dump_data(c_dump_data),
    .busy(c_busy), .done(c_done), .timeout(c_timeout), .cycles_run(c_cycles));

  // DMEM models: mem[i] = i*3, data returned exactly one cycle after the strobe
  always @(posedge clock) a_rd_data <= a_rd_en ? ({12'd0, a_rd_addr} * 16'd3) : 16'hDEAD;
  always @(posedge clock) b_rd_data <= b_rd_en ? ({12'd0, b_rd_addr} * 16'd3) : 16'hDEAD;
  always @(posedge clock) c_rd_data <= c_rd_en ? ({12'd0, c_rd_addr} * 16'd3) : 16'hDEAD;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Accept words on A until the given address is presented (left unaccepted).
  task automatic wait_word_a(input int a);
    int k;
    k = 0;
    while (!(a_valid && a_dump_addr == 4'(a)) && k < 100) begin
      if (a_valid) a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      k++;
    end
    chk($sformatf("reach_word_%0d", a), 32'(a_valid && a_dump_addr == 4'(a)), 1);
  endtask

  task automatic chk_a_zero(input string pfx);
    chk({pfx, "_cpu_en"}, a_cpu_en, 0);
    chk({pfx, "_rd_en"}, a_rd_en, 0);
    chk({pfx, "_rd_addr"}, a_rd_addr, 0);
    chk({pfx, "_valid"}, a_valid, 0);
    chk({pfx, "_dump_addr"}, a_dump_addr, 0);
    chk({pfx, "_dump_data"}, a_dump_data, 0);
    chk({pfx, "_busy"}, a_busy, 0);
    chk({pfx, "_done"}, a_done, 0);
    chk({pfx, "_timeout"}, a_timeout, 0);
    chk({pfx, "_cycles"}, a_cycles, 0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk_a_zero("rst");
    chk("rst_c_done", c_done, 0);

    // Budget run on A: cpu_en for exactly 8 cycles, then full dump
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("run_busy", a_busy, 1);
    cnt = 0;
    for (int i = 0; i < 20 && a_cpu_en; i++) begin cnt++; tick(); end
    chk("budget_en_cycles", cnt, 8);
    chk("budget_cycles_run", a_cycles, 8);
    chk("budget_timeout", a_timeout, 1);
    chk("budget_rd_en", a_rd_en, 1);
    chk("budget_rd_addr", a_rd_addr, 0);
    a_ready = 1'b1; words = 0; cyc = 0;
    while (!a_done && cyc < 200) begin
      if (a_valid) begin
        chk("dump_addr", a_dump_addr, words);
        chk("dump_data", a_dump_data, words * 3);
        words++;
      end
      tick(); cyc++;
    end
    a_ready = 1'b0;
    chk("dump_cycles", cyc, 48);
    chk("dump_words", words, 16);
    chk("dump_done", a_done, 1);
    chk("dump_busy", a_busy, 0);
    chk("dump_valid_off", a_valid, 0);
    chk("done_cycles_hold", a_cycles, 8);
    chk("done_timeout_hold", a_timeout, 1);

    // Restart from DONE; halt coincides with the final budget cycle
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("restart_done_clr", a_done, 0);
    chk("restart_cycles_clr", a_cycles, 0);
    chk("restart_cpu_en", a_cpu_en, 1);
    repeat (7) tick();
    a_halt = 1'b1; tick(); a_halt = 1'b0;
    chk("coinc_cycles", a_cycles, 8);
    chk("coinc_timeout", a_timeout, 0);
    chk("coinc_cpu_en", a_cpu_en, 0);

    // Backpressure on word 3
    wait_word_a(3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", a_valid, 1);
      chk("bp_addr", a_dump_addr, 3);
      chk("bp_data", a_dump_data, 9);
      chk("bp_no_read", a_rd_en, 0);
    end
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    chk("bp_drop_valid", a_valid, 0);
    chk("bp_next_rd_en", a_rd_en, 1);
    chk("bp_next_rd_addr", a_rd_addr, 4);

    // Reset while presenting word 7
    wait_word_a(7);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_a_zero("midrst");
    tick();
    chk("midrst_idle", a_busy, 0);

    // Fresh run dumps from address 0
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("fresh_cpu_en", a_cpu_en, 1);
    wait_word_a(0);
    chk("fresh_first_data", a_dump_data, 0);
    a_ready = 1'b1; cyc = 0;
    while (!a_done && cyc < 200) begin tick(); cyc++; end
    a_ready = 1'b0;
    chk("fresh_done", a_done, 1);

    // Early halt on B at the 5th RUN cycle
    b_start = 1'b1; tick(); b_start = 1'b0;
    repeat (4) tick();
    chk("halt_en_before", b_cpu_en, 1);
    b_halt = 1'b1; tick(); b_halt = 1'b0;
    chk("halt_cycles", b_cycles, 5);
    chk("halt_timeout", b_timeout, 0);
    chk("halt_cpu_en", b_cpu_en, 0);
    chk("halt_rd_en", b_rd_en, 1);
    b_ready = 1'b1; cyc = 0;
    while (!b_done && cyc < 200) begin tick(); cyc++; end
    b_ready = 1'b0;
    chk("halt_done", b_done, 1);
    chk("halt_cycles_hold", b_cycles, 5);

    // DEPTH=4 build, run twice to cover restart from DONE
    for (int r = 0; r < 2; r++) begin
      c_start = 1'b1; tick(); c_start = 1'b0;
      c_ready = 1'b1; words = 0; cyc = 0;
      while (!c_done && cyc < 200) begin
        if (c_valid) begin
          chk("d4_addr", c_dump_addr, words);
          chk("d4_data", c_dump_data, words * 3);
          words++;
        end
        tick(); cyc++;
      end
      c_ready = 1'b0;
      chk("d4_words", words, 4);
      chk("d4_done", c_done, 1);
      chk("d4_cycles", c_cycles, 8);
      chk("d4_timeout", c_timeout, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
